// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential PC, a 2-entry {pc, instr} buffer toward
// decode, branch/jump redirect with flush, and a sticky fault on bad fetch PCs.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      r_fifo [2];
  logic        r_head;
  logic [1:0]  r_count;
  logic [31:0] r_pc;
  logic        r_fault;

  logic        w_pop;
  logic        w_room;
  logic        w_attempt;
  logic        w_pc_ok;
  logic        w_push;
  logic        w_fault_set;
  logic        w_tail;
  logic [1:0]  w_count_nxt;
  entry_t      w_head_entry;

  assign w_pop     = (r_count != 2'd0) && ready_i;
  // A full buffer still has room when its head leaves in the same cycle.
  assign w_room    = (r_count != 2'd2) || w_pop;
  assign w_attempt = !r_fault && !redirect_i && w_room;
  // Wrapped PCs are always above LAST_PC, so the range test covers them too.
  assign w_pc_ok   = (r_pc <= LAST_PC) && (r_pc[1:0] == 2'b00);
  assign w_push    = w_attempt && w_pc_ok;
  assign w_fault_set = (redirect_i && (redirect_pc_i[1:0] != 2'b00)) ||
                       (w_attempt && !w_pc_ok);
  assign w_tail    = r_head ^ r_count[0];

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (redirect_i) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc    <= RESET_PC;
      r_head  <= 1'b0;
      r_count <= 2'd0;
      r_fault <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_fault <= r_fault | w_fault_set;
      if (redirect_i) begin
        r_pc <= redirect_pc_i;
      end else if (w_push) begin
        r_pc <= r_pc + 32'd4;
      end
      if (!redirect_i && w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

  // NOTE: the two buffer slots are reset because instr_o/pc_o must read zero
  // during reset; larger storage arrays would normally be left unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo[w_tail] <= '{pc: r_pc, instr: imem_rdata_i};
    end
  end

  assign w_head_entry = r_fifo[r_head];
  assign imem_addr_o  = r_pc;
  assign valid_o      = (r_count != 2'd0);
  assign instr_o      = w_head_entry.instr;
  assign pc_o         = w_head_entry.pc;
  assign fault_o      = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard queue of expected
// {pc, instr} transfers plus per-scenario checks on stall, redirect and faults.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(4096)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .valid_o      (valid),
    .ready_i      (ready),
    .instr_o      (instr),
    .pc_o         (pc),
    .fault_o      (fault)
  );

  // Memory word k (byte address 4k) holds the value k.
  assign imem_rdata = {2'b00, imem_addr[31:2]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  function automatic void push_exp(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = {2'b00, p[31:2]};
    sb_q.push_back(e);
  endfunction

  // Scoreboard monitor: a transfer happens at the next rising edge when
  // valid && ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: got pc=%h instr=%h, required no transfer", pc, instr);
      end else begin
        mon_e = sb_q.pop_front();
        if (pc !== mon_e.pc || instr !== mon_e.instr) begin
          errors++;
          $display("FAIL transfer: got pc=%h instr=%h, required pc=%h instr=%h",
                   pc, instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    redirect = 1'b0;
    ready    = rdy;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cycles, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    ready = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries still expected, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    ready       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #2;
    checks++;
    if (valid !== 1'b0 || fault !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b fault=%b pc=%h instr=%h addr=%h, required 0/0/0/0/0",
               valid, fault, pc, instr, imem_addr);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) push_exp(32'(4 * k));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL stream_first: got valid=%b pc=%h instr=%h addr=%h, required 1/0/0/4",
               valid, pc, instr, imem_addr);
    end
    drain(20, "stream");
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i >= 1) begin
        checks++;
        if (imem_addr !== 32'h8 || valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_addr: cycle %0d got addr=%h valid=%b, required 8/1", i, imem_addr, valid);
        end
      end
    end
    checks++;
    if (pc !== 32'h0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL stall_head: got pc=%h instr=%h, required 0/0", pc, instr);
    end
    for (int k = 0; k < 5; k++) push_exp(32'(4 * k));
    ready = 1'b1;
    drain(20, "stall");
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (valid !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL redirect_full: got valid=%b addr=%h, required 1/8", valid, imem_addr);
    end
    push_exp(32'h0);
    ready       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_flush: got valid=%b addr=%h, required 0/100", valid, imem_addr);
    end
    push_exp(32'h100);
    push_exp(32'h104);
    drain(20, "redirect");
  endtask

  task automatic test_misalign();
    do_reset(1'b0);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'h102) begin
      errors++;
      $display("FAIL misalign_fault: got fault=%b valid=%b addr=%h, required 1/0/102",
               fault, valid, imem_addr);
    end
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL misalign_no_fetch: cycle %0d got valid=%b, required 0", i, valid);
      end
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL misalign_sticky: got fault=%b valid=%b addr=%h, required 1/0/0",
               fault, valid, imem_addr);
    end
    ready = 1'b0;
  endtask

  task automatic test_range();
    bit seen_last = 1'b0;
    do_reset(1'b0);
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL range_reset_clears_fault: got fault=%b addr=%h, required 0/0", fault, imem_addr);
    end
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 32'hFF8;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    checks++;
    if (valid !== 1'b0 || imem_addr !== 32'hFF8) begin
      errors++;
      $display("FAIL range_redirect: got valid=%b addr=%h, required 0/ff8", valid, imem_addr);
    end
    push_exp(32'hFF8);
    push_exp(32'hFFC);
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (valid && pc == 32'hFFC) begin
        seen_last = 1'b1;
        checks++;
        if (fault !== 1'b0) begin
          errors++;
          $display("FAIL range_early_fault: got fault=%b with head ffc, required 0", fault);
        end
      end
    end
    ready = 1'b0;
    checks++;
    if (!seen_last || fault !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'h1000 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL range_end: got seen_ffc=%b fault=%b valid=%b addr=%h pending=%0d, required 1/1/0/1000/0",
               seen_last, fault, valid, imem_addr, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_midop();
    do_reset(1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_prefill: got valid=%b, required 1", valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || fault !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async: got valid=%b fault=%b pc=%h instr=%h addr=%h, required 0/0/0/0/0",
               valid, fault, pc, instr, imem_addr);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(32'(4 * k));
    ready = 1'b1;
    drain(20, "midreset");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign();
    test_range();
    test_reset_midop();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter MEM_BYTES, default 4096, the instruction memory size in bytes.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr_o  output  32  byte address to the instruction memory.
REQ-006 SHALL have port imem_rdata_i  input  32  instruction word from memory, combinational from imem_addr_o in the same cycle.
REQ-007 SHALL have port redirect_i  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc_i  input  32  redirect target byte address.
REQ-009 SHALL have port valid_o  output  1  instr_o and pc_o hold a valid entry.
REQ-010 SHALL have port ready_i  input  1  decode accepts the entry; transfer when valid_o && ready_i.
REQ-011 SHALL have port instr_o  output  32  instruction at the FIFO head.
REQ-012 SHALL have port pc_o  output  32  byte address of instr_o.
REQ-013 SHALL have port fault_o  output  1  sticky fetch fault (misaligned or out-of-range PC).

Function
REQ-014 SHALL keep a fetch PC register pc_q; imem_addr_o SHALL equal pc_q combinationally.
REQ-015 SHALL buffer fetched {pc, instr} pairs in a 2-entry FIFO; valid_o = (count != 0); instr_o/pc_o = head entry.
REQ-016 Fetch SHALL occur in a cycle when fault_o=0, redirect_i=0, pc_q is in range, and (count<2 or a transfer occurs); it pushes {pc_q, imem_rdata_i} and sets pc_q <= pc_q + 4.
REQ-017 Full FIFO with no transfer SHALL hold pc_q and not push (stall); imem_addr_o stays stable.
REQ-018 Push and pop in the same cycle SHALL keep count unchanged and preserve order.
REQ-019 Latency: an entry fetched at edge N SHALL be visible on valid_o/instr_o after edge N; head changes only on transfer.
REQ-020 redirect_i=1 SHALL, at the next edge, flush the FIFO (count=0), set pc_q <= redirect_pc_i, and perform no push; valid_o is 0 in the following cycle.
REQ-021 Simultaneous redirect and transfer SHALL count the head as delivered; remaining entries are discarded; redirect wins over fetch.
REQ-022 Redirect with redirect_pc_i[1:0] != 0 SHALL set fault_o at the next edge and still load pc_q; no further fetches occur.
REQ-023 pc_q > MEM_BYTES-4 at a would-be fetch SHALL set fault_o at that edge with no push.
REQ-024 fault_o SHALL stay 1 until reset; entries already in the FIFO SHALL still drain normally; a later redirect SHALL neither clear the fault nor resume fetching.
REQ-025 pc_q + 4 SHALL wrap modulo 2^32; any wrapped value is out of range per REQ-023.

Reset
REQ-026 rst_ni=0 SHALL immediately (asynchronously) set pc_q=RESET_PC, count=0, valid_o=0, fault_o=0; instr_o/pc_o SHALL read 0.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents and any pending redirect.
REQ-028 The first fetch SHALL occur at the first rising edge with rst_ni=1.

Verification
REQ-029 Reset release, ready_i=1, memory word k = k -> pc_o/instr_o stream 0/0, 4/1, 8/2, ... one per cycle from cycle 1.
REQ-030 ready_i=0 for 5 cycles -> count saturates at 2, pc_q=8, imem_addr_o=8 stable; on ready_i=1 entries 0, 4, 8 delivered in order, no loss or duplicate.
REQ-031 redirect_i=1, redirect_pc_i=0x100 with a full FIFO and ready_i=1 -> head transferred, other entry dropped, valid_o=0 next cycle, then pc_o=0x100.
REQ-032 redirect_pc_i=0x102 -> fault_o=1 next cycle, no new valid entries, fault persists after a later redirect to 0x0.
REQ-033 Fetch reaching pc_q=0xFFC then 0x1000 -> entry 0xFFC delivered, fault_o=1 at the 0x1000 attempt, no 0x1000 entry.
REQ-034 rst_ni pulsed low mid-cycle with 2 entries buffered -> valid_o=0 and fault_o=0 immediately; restart at RESET_PC.
